pwm_multi_channel: RTL and testbench

//   CH-channel PWM generator with parametrised resolution and prescaler.
//   All channels share one period counter, so their periods are phase-aligned.

---
 rtl/pwm_multi_channel_if.sv | 12 +
 rtl/pwm_multi_channel.sv | 129 ++++++++++++
 tb/tb_pwm_multi_channel.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_channel_if.sv
// Write bus for pwm_multi_channel: strobe, channel select and duty value.
interface pwm_multi_channel_if #(
    parameter int CH_BITS = 2,
    parameter int WIDTH   = 8
);
    logic               WR_EN;
    logic [CH_BITS-1:0] WR_CH;
    logic [WIDTH-1:0]   WR_DUTY;

    modport master (output WR_EN, WR_CH, WR_DUTY);
    modport slave  (input  WR_EN, WR_CH, WR_DUTY);
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared prescaled period counter and double-buffered duties.
// Define PWM_CENTER_ALIGN_EN for a centre-aligned (triangle) counter instead of edge-aligned.
module pwm_multi_channel #(
    parameter int CH       = 4,
    parameter int CH_BITS  = 2,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 120
) (
    input  logic                 CLK,
    input  logic                 RST,
    pwm_multi_channel_if.slave   bus,
    output logic                 PERIOD_END,
    output logic [CH-1:0]        MOUT
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc;
    logic             tick;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic             reload;
    logic [WIDTH-1:0] shadow [CH];
    logic [WIDTH-1:0] active [CH];
    logic [CH-1:0]    mout_next;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge CLK) begin
        if (RST || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    dir_t dir;
    dir_t dir_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_next;
            dir <= dir_next;
        end
    end

    // The valley (cnt==0 while heading down) is held for one tick and is the reload point.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        reload   = 1'b0;
        if (tick) begin
            if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    dir_next = DIR_DOWN;
                    cnt_next = cnt - 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    dir_next = DIR_UP;
                    cnt_next = cnt + 1'b1;
                    reload   = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    always_comb begin
        cnt_next = cnt;
        reload   = 1'b0;
        if (tick) begin
            cnt_next = cnt + 1'b1;
            reload   = (cnt == MAX);
        end
    end
`endif

    // Reload samples the pre-write shadow value, so a colliding write lands a period later.
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (RST) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end else begin
                if (bus.WR_EN && (bus.WR_CH == CH_BITS'(i))) begin
                    shadow[i] <= bus.WR_DUTY;
                end
                if (reload) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    always_comb begin
        mout_next = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            mout_next[i] = (cnt < active[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MOUT       <= '0;
            PERIOD_END <= 1'b0;
        end else begin
            MOUT       <= mout_next;
            PERIOD_END <= reload;
        end
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomised self-checking bench for pwm_multi_channel against a time-arithmetic reference model.
module tb_pwm_multi_channel;
    localparam int CH       = 2;
    localparam int CH_BITS  = 1;
    localparam int WIDTH    = 4;
    localparam int PRESCALE = 2;
    localparam int MAX      = 15;
`ifdef PWM_CENTER_ALIGN_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif
    localparam int PERIOD_TICKS = CENTER ? 2 * MAX : MAX + 1;
    localparam int PERIOD_CLK   = PERIOD_TICKS * PRESCALE;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          PERIOD_END;
    logic [CH-1:0] MOUT;

    pwm_multi_channel_if #(.CH_BITS(CH_BITS), .WIDTH(WIDTH)) bus_if ();

    pwm_multi_channel #(
        .CH(CH), .CH_BITS(CH_BITS), .WIDTH(WIDTH), .PRESCALE(PRESCALE)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus_if.slave),
        .PERIOD_END(PERIOD_END), .MOUT(MOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Model: e = clock edges since reset release; counter derived from e arithmetically.
    int            e = 0;
    int            shadow [CH];
    int            active [CH];
    logic [CH-1:0] exp_mout = '0;
    logic          exp_pe = 1'b0;
    bit            last_reload = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int n);
        int m;
        int ph;
        m = n / PRESCALE;
        if (!CENTER) return m % (MAX + 1);
        ph = m % (2 * MAX);
        return (ph <= MAX) ? ph : 2 * MAX - ph;
    endfunction

    // True when the edge taking the model from n to n+1 is a reload.
    function automatic bit reload_at(input int n);
        int m;
        if ((n % PRESCALE) != PRESCALE - 1) return 1'b0;
        m = n / PRESCALE;
        if (!CENTER) return (m % (MAX + 1)) == MAX;
        return (m > 0) && ((m % (2 * MAX)) == 0);
    endfunction

    function automatic int exp_hi(input int d);
        if (!CENTER) return d * PRESCALE;
        return (d == 0) ? 0 : (2 * d - 1) * PRESCALE;
    endfunction

    task automatic step();
        int c;
        bit rl;
        @(posedge CLK);
        if (RST) begin
            e = 0;
            exp_mout = '0;
            exp_pe = 1'b0;
            last_reload = 1'b0;
            for (int i = 0; i < CH; i++) begin
                shadow[i] = 0;
                active[i] = 0;
            end
        end else begin
            c = cnt_of(e);
            rl = reload_at(e);
            for (int i = 0; i < CH; i++) exp_mout[i] = (c < active[i]);
            exp_pe = rl;
            last_reload = rl;
            if (rl) begin
                for (int i = 0; i < CH; i++) active[i] = shadow[i];
            end
            if (bus_if.WR_EN && (int'(bus_if.WR_CH) < CH)) shadow[bus_if.WR_CH] = int'(bus_if.WR_DUTY);
            e++;
        end
        #1;
        check("mout", 32'(MOUT), 32'(exp_mout));
        check("period_end", 32'(PERIOD_END), 32'(exp_pe));
    endtask

    task automatic write(input int ch, input int duty);
        bus_if.WR_EN   = 1'b1;
        bus_if.WR_CH   = CH_BITS'(ch);
        bus_if.WR_DUTY = WIDTH'(duty);
        step();
        bus_if.WR_EN   = 1'b0;
    endtask

    task automatic wait_reload();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_reload && n < 4 * PERIOD_CLK);
        if (!last_reload) check("wait_reload_timeout", 0, 1);
    endtask

    task automatic measure(output int hi0, output int hi1, output int pe);
        hi0 = 0;
        hi1 = 0;
        pe  = 0;
        for (int k = 0; k < PERIOD_CLK; k++) begin
            step();
            hi0 += int'(MOUT[0]);
            hi1 += int'(MOUT[1]);
            pe  += int'(PERIOD_END);
        end
    endtask

    initial begin
        int hi0, hi1, pe, n;
        bus_if.WR_EN   = 1'b0;
        bus_if.WR_CH   = '0;
        bus_if.WR_DUTY = '0;

        // Reset hold
        RST = 1'b1;
        repeat (5) step();
        RST = 1'b0;

        // Double buffering and extremes
        repeat (9) step();
        write(0, 5);
        write(1, 15);
        wait_reload();
        measure(hi0, hi1, pe);
        check("duty5_high", hi0, exp_hi(5));
        check("duty_max_high", hi1, exp_hi(15));
        check("pe_per_period", pe, 1);
        write(0, 0);
        wait_reload();
        measure(hi0, hi1, pe);
        check("duty0_high", hi0, 0);
        check("pe_per_period2", pe, 1);

        // Write collision on the reload edge
        write(0, 3);
        wait_reload();
        n = 0;
        while (!reload_at(e + 1) && n < 4 * PERIOD_CLK) begin
            step();
            n++;
        end
        write(1, 7);
        write(0, 9);
        if (!last_reload) check("collision_align", 0, 1);
        measure(hi0, hi1, pe);
        check("collision_old", hi0, exp_hi(3));
        check("collision_ch1", hi1, exp_hi(7));
        measure(hi0, hi1, pe);
        check("collision_new", hi0, exp_hi(9));
        check("collision_ch1_2", hi1, exp_hi(7));

        // Reset mid-operation
        n = 0;
        while (!(cnt_of(e) == 7 && exp_mout[0]) && n < 4 * PERIOD_CLK) begin
            step();
            n++;
        end
        check("pre_reset_high", 32'(MOUT[0]), 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        measure(hi0, hi1, pe);
        measure(hi0, hi1, pe);
        check("post_reset_ch0", hi0, 0);
        check("post_reset_ch1", hi1, 0);

        // Randomised writes against the model
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(7) == 0) begin
                write(int'($urandom_range(CH - 1)), int'($urandom_range(MAX)));
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
